tracer_center_loader: RTL and testbench



---
 rtl/tracer_pkg.sv | 17 +
 rtl/tracer_center_loader_fifo.sv | 52 +++++
 rtl/tracer_center_loader.sv | 156 +++++++++++++++
 tb/tb_tracer_center_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_pkg.sv
// Shared field offsets, image bounds and FSM state type for the tracer
// centre-load path.
package tracer_pkg;

  localparam int CENTER_ROW_LSB   = 0;
  localparam int CENTER_COL_LSB   = 16;
  localparam int IMG_ROWS_DEFAULT = 240;
  localparam int IMG_COLS_DEFAULT = 320;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } load_state_t;

endpackage

// File: rtl/tracer_center_loader_fifo.sv
// Flop-based synchronous FIFO: head read straight from storage registers,
// occupancy count output, push and pop allowed together at any fill level.
module tracer_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The producer is expected to reserve space before issuing; a push into a full FIFO is a bug upstream.
  overflow_check: assert property (@(posedge s_axi_aclk) disable iff (!s_axi_aresetn)
    !(push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/tracer_center_loader.sv
// Centre-load controller: bursts n centre words from the tracer BRAM into a small
// FIFO feeding the contour tracer. Macro CENTER_BOUNDS_CHECK_EN drops off-image entries.
module tracer_center_loader
  import tracer_pkg::*;
#(
  parameter  int MAX_CENTERS = 64,
  parameter  int ROW_W       = 8,
  parameter  int COL_W       = 9,
  parameter  int RD_LAT      = 1,
  parameter  int FIFO_DEPTH  = 4,
  parameter  int IMG_ROWS    = IMG_ROWS_DEFAULT,
  parameter  int IMG_COLS    = IMG_COLS_DEFAULT,
  localparam int IDX_W       = $clog2(MAX_CENTERS + 1)
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             load_start,
  input  logic [IDX_W-1:0] num_centers,
  output logic             busy,
  output logic             load_done,
  output logic             center_valid,
  input  logic             center_ready,
  output logic [ROW_W-1:0] center_row,
  output logic [COL_W-1:0] center_col,
  output logic [IDX_W-2:0] center_idx,
  output logic [IDX_W-1:0] oob_count,
  output logic             tracer_buf_en,
  output logic [31:0]      tracer_buf_addr,
  input  logic [31:0]      tracer_buf_din
);

  localparam int ENTRY_W = (IDX_W - 1) + COL_W + ROW_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  load_state_t        state, state_next;
  logic [IDX_W-1:0]   n_tgt;
  logic [IDX_W-1:0]   num_clamped;
  logic [IDX_W-2:0]   rd_idx;
  logic [IDX_W-2:0]   cap_idx;
  logic [RD_LAT-1:0]  issue_sr;
  logic               accept;
  logic               has_room;
  logic               last_read;
  logic               drained;
  logic               capture;
  logic [ROW_W-1:0]   cap_row;
  logic [COL_W-1:0]   cap_col;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_valid;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               unused_din;

  assign accept      = (state == IDLE) && load_start;
  assign num_clamped = (num_centers > IDX_W'(MAX_CENTERS)) ? IDX_W'(MAX_CENTERS) : num_centers;
  assign has_room    = (int'(fifo_count) + $countones(issue_sr)) < FIFO_DEPTH;
  assign last_read   = (IDX_W'(rd_idx) == (n_tgt - IDX_W'(1)));
  assign capture     = issue_sr[RD_LAT-1];
  assign cap_row     = tracer_buf_din[CENTER_ROW_LSB +: ROW_W];
  assign cap_col     = tracer_buf_din[CENTER_COL_LSB +: COL_W];
  assign unused_din  = ^tracer_buf_din;
  assign fifo_pop    = fifo_valid && center_ready;
  // Finishing on the cycle the last entry leaves lets load_done follow the final transfer directly.
  assign drained     = (issue_sr == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  assign tracer_buf_addr = {{(31 - IDX_W){1'b0}}, rd_idx, 2'b00};

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_next;
  end

  // A zero-length load spends one cycle in READ without issuing, so busy is visible once.
  always_comb begin
    state_next    = state;
    tracer_buf_en = 1'b0;
    busy          = 1'b0;
    load_done     = 1'b0;
    case (state)
      IDLE: if (load_start) state_next = READ;
      READ: begin
        busy = 1'b1;
        if (n_tgt == '0) begin
          state_next = DONE;
        end else if (has_room) begin
          tracer_buf_en = 1'b1;
          if (last_read) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drained) state_next = DONE;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      n_tgt    <= '0;
      rd_idx   <= '0;
      cap_idx  <= '0;
      issue_sr <= '0;
    end else begin
      issue_sr <= (issue_sr << 1) | RD_LAT'(tracer_buf_en);
      if (accept) begin
        n_tgt   <= num_clamped;
        rd_idx  <= '0;
        cap_idx <= '0;
      end else begin
        if (tracer_buf_en && !last_read) rd_idx <= rd_idx + (IDX_W - 1)'(1);
        if (capture) cap_idx <= cap_idx + (IDX_W - 1)'(1);
      end
    end
  end

`ifdef CENTER_BOUNDS_CHECK_EN
  logic in_bounds;

  assign in_bounds = (int'(cap_row) < IMG_ROWS) && (int'(cap_col) < IMG_COLS);
  assign fifo_push = capture && in_bounds;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)                                             oob_count <= '0;
    else if (accept)                                                oob_count <= '0;
    else if (capture && !in_bounds && (oob_count != IDX_W'(MAX_CENTERS))) oob_count <= oob_count + IDX_W'(1);
  end
`else
  assign fifo_push = capture;
  assign oob_count = '0;
`endif

  tracer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .push          (fifo_push),
    .push_data     ({cap_idx, cap_col, cap_row}),
    .pop           (fifo_pop),
    .head_data     (fifo_head),
    .head_valid    (fifo_valid),
    .count         (fifo_count)
  );

  assign center_valid = fifo_valid;
  assign {center_idx, center_col, center_row} = fifo_head;

endmodule

// File: tb/tb_tracer_center_loader.sv
// Bench for tracer_center_loader: instances with BRAM latency 1 (a) and 3 (b), driven
// one at a time and checked against an expected-entry queue built from the BRAM image.
`timescale 1ns/1ps
module tb_tracer_center_loader;

  localparam int IDX_W = 7;
  localparam int MAXC  = 64;
  localparam int ROWS  = 240;
  localparam int COLS  = 320;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [5:0] idx;
    logic [8:0] col;
    logic [7:0] row;
  } entry_t;

  logic s_axi_aclk = 1'b0;
  logic s_axi_aresetn = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  int cyc = 0;
  always @(posedge s_axi_aclk) cyc <= cyc + 1;

  int sel = 0;
  int ready_mode = 0;
  int check_occ = 0;

  logic             start_a = 1'b0, start_b = 1'b0;
  logic [IDX_W-1:0] num_a = '0, num_b = '0;
  logic             ready_a, ready_b;
  logic             busy_a, busy_b, done_a, done_b, valid_a, valid_b, en_a, en_b;
  logic [7:0]       row_a, row_b;
  logic [8:0]       col_a, col_b;
  logic [5:0]       idx_a, idx_b;
  logic [IDX_W-1:0] oob_a, oob_b;
  logic [31:0]      addr_a, addr_b, din_a, din_b, pipe_b0, pipe_b1;

  assign ready_a = (sel == 0) && ((ready_mode == 0) || ((cyc % 3) == 0));
  assign ready_b = (sel == 1) && ((ready_mode == 0) || ((cyc % 3) == 0));

  tracer_center_loader #(.RD_LAT(1)) u_dut_a (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .load_start(start_a),
    .num_centers(num_a), .busy(busy_a), .load_done(done_a), .center_valid(valid_a),
    .center_ready(ready_a), .center_row(row_a), .center_col(col_a), .center_idx(idx_a),
    .oob_count(oob_a), .tracer_buf_en(en_a), .tracer_buf_addr(addr_a), .tracer_buf_din(din_a));

  tracer_center_loader #(.RD_LAT(3)) u_dut_b (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .load_start(start_b),
    .num_centers(num_b), .busy(busy_b), .load_done(done_b), .center_valid(valid_b),
    .center_ready(ready_b), .center_row(row_b), .center_col(col_b), .center_idx(idx_b),
    .oob_count(oob_b), .tracer_buf_en(en_b), .tracer_buf_addr(addr_b), .tracer_buf_din(din_b));

  // BRAM models: read data appears 1 (a) or 3 (b) cycles after the enable.
  logic [31:0] bram [MAXC];
  always @(posedge s_axi_aclk) if (en_a) din_a <= bram[addr_a[7:2]];
  always @(posedge s_axi_aclk) begin
    if (en_b) pipe_b0 <= bram[addr_b[7:2]];
    pipe_b1 <= pipe_b0;
    din_b   <= pipe_b1;
  end

  logic        cur_valid, cur_ready, cur_busy, cur_done, cur_en;
  logic [31:0] cur_addr;
  logic [22:0] cur_head;
  always_comb begin
    if (sel == 0) begin
      cur_valid = valid_a; cur_ready = ready_a; cur_busy = busy_a; cur_done = done_a;
      cur_en = en_a; cur_addr = addr_a; cur_head = {idx_a, col_a, row_a};
    end else begin
      cur_valid = valid_b; cur_ready = ready_b; cur_busy = busy_b; cur_done = done_b;
      cur_en = en_b; cur_addr = addr_b; cur_head = {idx_b, col_b, row_b};
    end
  end

  int total = 0;
  int bad = 0;
  entry_t exp_q[$];
  int exp_oob;
  int start_cyc = 0, rel;
  int rd_cnt, xfer_cnt, done_cnt, busy_cnt;
  int first_valid_rel, first_en_rel, done_rel, last_xfer_rel;
  logic [31:0] last_addr;
  logic        prev_hold = 1'b0;
  logic [22:0] prev_head;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Expected stream: the first min(num, MAXC) words in index order, off-image ones removed when checking is built in.
  task automatic buildModel(input int num);
    int n;
    entry_t e;
    n = (num > MAXC) ? MAXC : num;
    exp_q.delete();
    exp_oob = 0;
    for (int k = 0; k < n; k++) begin
      e.idx = 6'(k);
      e.row = bram[k][7:0];
      e.col = bram[k][24:16];
`ifdef CENTER_BOUNDS_CHECK_EN
      if ((int'(e.row) >= ROWS) || (int'(e.col) >= COLS)) exp_oob++;
      else exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
  endtask

  always @(negedge s_axi_aclk) begin
    rel = cyc - start_cyc;
    if (!s_axi_aresetn) begin
      prev_hold = 1'b0;
    end else begin
      if (cur_busy) busy_cnt++;
      if (cur_en) begin
        checkOutput("rd_addr", cur_addr, 32'(rd_cnt * 4));
        if (check_occ != 0)
          checkOutput("occupancy_le_depth", ((rd_cnt + 1 - xfer_cnt) <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        if (first_en_rel < 0) first_en_rel = rel;
        rd_cnt++;
        last_addr = cur_addr;
      end
      if (prev_hold) begin
        checkOutput("stall_valid", 32'(cur_valid), 32'd1);
        checkOutput("stall_head", 32'(cur_head), 32'(prev_head));
      end
      if (cur_valid && (first_valid_rel < 0)) first_valid_rel = rel;
      if (cur_valid && cur_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL extra_entry: got head 0x%0h, want no entry", cur_head);
        end else begin
          checkOutput("head", 32'(cur_head), 32'(exp_q.pop_front()));
        end
        xfer_cnt++;
        last_xfer_rel = rel;
      end
      if (cur_done) begin
        done_cnt++;
        done_rel = rel;
        checkOutput("busy_at_done", 32'(cur_busy), 32'd0);
        checkOutput("pending_at_done", 32'(exp_q.size()), 32'd0);
      end
      prev_hold = cur_valid && !cur_ready;
      prev_head = cur_head;
    end
  end

  task automatic applyStimulus(input int which, input int num);
    @(posedge s_axi_aclk); #1;
    sel = which;
    rd_cnt = 0; xfer_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_valid_rel = -1; first_en_rel = -1; done_rel = -1; last_xfer_rel = -1;
    last_addr = '0;
    buildModel(num);
    start_cyc = cyc;
    if (which == 0) begin start_a = 1'b1; num_a = IDX_W'(num); end
    else            begin start_b = 1'b1; num_b = IDX_W'(num); end
    @(posedge s_axi_aclk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    int n;
    n = 0;
    while ((done_cnt == 0) && (n < max_cycles)) begin
      @(posedge s_axi_aclk);
      n++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no load_done in %0d cycles, want one", max_cycles);
    end
    repeat (3) @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_a), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy_a),  32'd0);
    checkOutput({tag, "_done"},  32'(done_a),  32'd0);
    checkOutput({tag, "_en"},    32'(en_a),    32'd0);
    checkOutput({tag, "_addr"},  addr_a,       32'd0);
    checkOutput({tag, "_head"},  32'({idx_a, col_a, row_a}), 32'd0);
    checkOutput({tag, "_oob"},   32'(oob_a),   32'd0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < MAXC; k++) bram[k] = {7'd0, 9'(k + 100), 8'd0, 8'(k)};

    repeat (3) @(posedge s_axi_aclk);
    #1;
    checkZeroOutputs("reset");
    s_axi_aresetn = 1'b1;

    $display("[TB] basic run: 64 centres, latency 1, ready high");
    applyStimulus(0, 64);
    waitDone(200);
    checkOutput("basic_first_en", 32'(first_en_rel), 32'd1);
    checkOutput("basic_first_valid", 32'(first_valid_rel), 32'd3);
    checkOutput("basic_last_xfer", 32'(last_xfer_rel), 32'd66);
    checkOutput("basic_done_cycle", 32'(done_rel), 32'd67);
    checkOutput("basic_xfers", 32'(xfer_cnt), 32'd64);
    checkOutput("basic_reads", 32'(rd_cnt), 32'd64);
    checkOutput("basic_done_count", 32'(done_cnt), 32'd1);
    checkOutput("basic_busy_cycles", 32'(busy_cnt), 32'd66);

    $display("[TB] zero count");
    applyStimulus(0, 0);
    waitDone(20);
    checkOutput("zero_reads", 32'(rd_cnt), 32'd0);
    checkOutput("zero_done_cycle", 32'(done_rel), 32'd2);
    checkOutput("zero_busy_cycles", 32'(busy_cnt), 32'd1);
    checkOutput("zero_xfers", 32'(xfer_cnt), 32'd0);

    $display("[TB] backpressure: 10 centres, latency 3, ready 1 in 3");
    ready_mode = 1;
    check_occ = 1;
    applyStimulus(1, 10);
    waitDone(300);
    checkOutput("bp_first_valid", 32'(first_valid_rel), 32'd5);
    checkOutput("bp_xfers", 32'(xfer_cnt), 32'd10);
    checkOutput("bp_reads", 32'(rd_cnt), 32'd10);
    checkOutput("bp_done_count", 32'(done_cnt), 32'd1);
    ready_mode = 0;
    check_occ = 0;

    $display("[TB] clamp and ignored restart");
    applyStimulus(0, 100);
    repeat (18) @(posedge s_axi_aclk);
    #1;
    start_a = 1'b1;
    num_a = IDX_W'(5);
    @(posedge s_axi_aclk); #1;
    start_a = 1'b0;
    waitDone(300);
    repeat (10) @(posedge s_axi_aclk);
    #1;
    checkOutput("clamp_reads", 32'(rd_cnt), 32'd64);
    checkOutput("clamp_last_addr", last_addr, 32'h0000_00FC);
    checkOutput("clamp_xfers", 32'(xfer_cnt), 32'd64);
    checkOutput("clamp_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] reset mid-burst");
    applyStimulus(0, 64);
    n = 0;
    while ((xfer_cnt < 20) && (n < 100)) begin
      @(posedge s_axi_aclk);
      n++;
    end
    if (xfer_cnt < 20) begin
      total++;
      bad++;
      $display("[TB] FAIL reset_wait_timeout: got %0d transfers, want 20", xfer_cnt);
    end
    #2;
    s_axi_aresetn = 1'b0;
    exp_q.delete();
    #1;
    checkZeroOutputs("midreset");
    repeat (4) @(posedge s_axi_aclk);
    #1;
    s_axi_aresetn = 1'b1;
    repeat (4) @(posedge s_axi_aclk);
    #1;
    checkOutput("midreset_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(0, 5);
    waitDone(100);
    checkOutput("after_reset_xfers", 32'(xfer_cnt), 32'd5);
    checkOutput("after_reset_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] out-of-image rows");
    bram[2][7:0] = 8'd250;
    bram[5][7:0] = 8'd239;
    applyStimulus(0, 8);
    waitDone(100);
    checkOutput("bounds_done_count", 32'(done_cnt), 32'd1);
`ifdef CENTER_BOUNDS_CHECK_EN
    checkOutput("bounds_xfers", 32'(xfer_cnt), 32'd7);
    checkOutput("bounds_oob", 32'(oob_a), 32'd1);
`else
    checkOutput("bounds_xfers", 32'(xfer_cnt), 32'd8);
    checkOutput("bounds_oob", 32'(oob_a), 32'd0);
`endif
    checkOutput("bounds_model_oob", 32'(oob_a), 32'(exp_oob));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, want finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
